// File: rtl/lvds_host_sched_pkg.sv
// Shared widths, parameter defaults and state encoding for the LVDS host scheduler.
package lvds_host_sched_pkg;

    localparam int unsigned CMD_W           = 40;
    localparam int unsigned RSP_W           = 32;
    localparam int unsigned NREQ_DEFAULT    = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 1023;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/lvds_host_sched_rr_pick.sv
// Combinational round-robin selector: picks the first requester after last_grant.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic            any,
    output logic [IW-1:0]   idx
);

    int unsigned pos;

    always_comb begin
        any = |req;
        idx = '0;
        pos = 0;
        // Scan farthest-first so the nearest requester after last_grant overrides.
        for (int unsigned k = NREQ; k >= 1; k--) begin
            pos = (32'(last_grant) + k) % NREQ;
            if (req[pos[IW-1:0]]) begin
                idx = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/lvds_host_sched.sv
// Single-outstanding transaction scheduler between NREQ requesters and an LVDS host link.
module lvds_host_sched
    import lvds_host_sched_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                   c,
    input  logic                   rn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*CMD_W-1:0]  req_data,
    output logic [NREQ-1:0]        done,
    output logic [RSP_W-1:0]       rsp,
    output logic                   err,
    output logic                   busy,
    output logic                   wvalid,
    output logic [CMD_W-1:0]       wdata,
    input  logic                   rvalid,
    input  logic [RSP_W-1:0]       rdata
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_e          state;
    logic            ready;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   gnt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            pick_any;
    logic [IW-1:0]   pick_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant),
        .any        (pick_any),
        .idx        (pick_idx)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign busy    = (state != StIdle);

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state      <= StIdle;
            ready      <= 1'b0;
            last_grant <= IW'(NREQ - 1);
            gnt        <= '0;
            cnt        <= '0;
            wvalid     <= 1'b0;
            wdata      <= '0;
            done       <= '0;
            rsp        <= '0;
            err        <= 1'b0;
        end else begin
            // Holds off granting until one full clock after reset release.
            ready <= 1'b1;
            unique case (state)
                StIdle: begin
                    if (ready && pick_any) begin
                        gnt    <= pick_idx;
                        wdata  <= req_data[32'(pick_idx) * CMD_W +: CMD_W];
                        wvalid <= 1'b1;
                        state  <= StIssue;
                    end
                end
                StIssue: begin
                    wvalid <= 1'b0;
                    cnt    <= '0;
                    state  <= StWait;
                end
                StWait: begin
                    cnt <= cnt_inc;
                    // A response arriving on the timeout cycle takes precedence.
                    if (rvalid) begin
                        rsp       <= rdata;
                        err       <= 1'b0;
                        done[gnt] <= 1'b1;
                        state     <= StDone;
                    end else if (cnt_inc == CNT_MAX) begin
                        rsp       <= '0;
                        err       <= 1'b1;
                        done[gnt] <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    done       <= '0;
                    last_grant <= gnt;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lvds_host_sched.sv
// Directed bench for lvds_host_sched with an event-timeline reference model.
module tb_lvds_host_sched;
    import lvds_host_sched_pkg::*;

    localparam int N = 4;
    localparam int T = 1023;

    logic            c        = 1'b0;
    logic            rn       = 1'b1;
    logic [N-1:0]    req      = '0;
    logic [N*40-1:0] req_data = '0;
    logic            rvalid   = 1'b0;
    logic [31:0]     rdata    = '0;
    logic [N-1:0]    done;
    logic [31:0]     rsp;
    logic            err;
    logic            busy;
    logic            wvalid;
    logic [39:0]     wdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 c = ~c;

    lvds_host_sched #(
        .NREQ    (N),
        .TIMEOUT (T)
    ) dut (
        .c        (c),
        .rn       (rn),
        .req      (req),
        .req_data (req_data),
        .done     (done),
        .rsp      (rsp),
        .err      (err),
        .busy     (busy),
        .wvalid   (wvalid),
        .wdata    (wdata),
        .rvalid   (rvalid),
        .rdata    (rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: timeline of grant edge, resolve edge and release edge per transaction.
    int          cyc      = 0;
    bit          m_ready  = 0;
    bit          m_active = 0;
    int          g_edge   = 0;
    int          gidx     = 0;
    int          res_edge = -1;
    int          last     = N - 1;
    logic        e_wvalid = 1'b0;
    logic [39:0] e_wdata  = '0;
    logic [N-1:0] e_done  = '0;
    logic [31:0] e_rsp    = '0;
    logic        e_err    = 1'b0;

    initial forever begin
        @(posedge c or negedge rn);
        if (!rn) begin
            cyc = 0; m_ready = 0; m_active = 0; res_edge = -1; last = N - 1;
            e_wvalid = 1'b0; e_wdata = '0; e_done = '0; e_rsp = '0; e_err = 1'b0;
        end else begin
            cyc++;
            e_wvalid = 1'b0;
            e_done   = '0;
            if (m_active) begin
                if (res_edge < 0 && cyc >= g_edge + 2) begin
                    if (rvalid) begin
                        res_edge = cyc; e_rsp = rdata; e_err = 1'b0; e_done[gidx] = 1'b1;
                    end else if (cyc == g_edge + T + 1) begin
                        res_edge = cyc; e_rsp = '0; e_err = 1'b1; e_done[gidx] = 1'b1;
                    end
                end else if (res_edge >= 0 && cyc == res_edge + 1) begin
                    m_active = 0;
                    last     = gidx;
                end
            end else if (m_ready && req != '0) begin
                for (int k = N; k >= 1; k--) if (req[(last + k) % N]) gidx = (last + k) % N;
                g_edge   = cyc;
                res_edge = -1;
                m_active = 1;
                e_wvalid = 1'b1;
                e_wdata  = req_data[gidx*40 +: 40];
            end
            m_ready = 1;
        end
    end

    int ncyc = 0, wv_cnt = 0, done_cnt = 0, wv_cyc = 0, done_cyc = 0;
    int done_log[$];

    initial forever begin
        @(negedge c);
        ncyc++;
        chk("wvalid", wvalid, e_wvalid);
        chk("wdata",  wdata,  e_wdata);
        chk("done",   done,   e_done);
        chk("rsp",    rsp,    e_rsp);
        chk("err",    err,    e_err);
        chk("busy",   busy,   m_active);
        if (wvalid) begin wv_cnt++; wv_cyc = ncyc; end
        if (done != '0) begin
            done_cnt++;
            done_cyc = ncyc;
            for (int i = 0; i < N; i++) if (done[i]) done_log.push_back(i);
        end
    end

    task automatic cyc_in(input int n);
        repeat (n) @(posedge c);
        #2;
    endtask

    task automatic sample();
        @(negedge c);
        #1;
    endtask

    task automatic wait_wv(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            sample();
            if (wvalid) begin ok = 1; break; end
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            sample();
            if (done != '0) begin ok = 1; break; end
        end
    endtask

    bit ok;
    int base_wv, base_done;
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        #1 rn = 1'b0;
        cyc_in(3);
        rn = 1'b1;
        cyc_in(2);

        // Single transaction answered after 300 WAIT cycles.
        req_data[39:0] = 40'h12_3456_789A;
        req = 4'b0001;
        sample();
        chk("a_pre_issue_wvalid", wvalid, 1'b0);
        sample();
        chk("a_issue_wvalid", wvalid, 1'b1);
        chk("a_issue_wdata", wdata, 40'h12_3456_789A);
        cyc_in(1);
        req = '0;
        cyc_in(299);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        cyc_in(1);
        rvalid = 1'b0;
        sample();
        chk("a_done", done, 4'b0001);
        chk("a_rsp", rsp, 32'hDEAD_BEEF);
        chk("a_err", err, 1'b0);

        // Round-robin fairness with all requesters held.
        rn = 1'b0; cyc_in(2); rn = 1'b1; cyc_in(2);
        for (int i = 0; i < N; i++) req_data[i*40 +: 40] = 40'hB0_0000_0000 + 40'(i);
        done_log.delete();
        base_wv = wv_cnt; base_done = done_cnt;
        req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            wait_wv(10, ok);
            chk("b_wvalid_seen", ok, 1'b1);
            chk("b_wdata", wdata, 40'hB0_0000_0000 + 40'(t % 4));
            cyc_in(1);
            rvalid = 1'b1; rdata = 32'hC0DE_0000 + 32'(t);
            cyc_in(1);
            rvalid = 1'b0;
        end
        req = '0;
        cyc_in(4);
        sample();
        chk("b_wv_count", wv_cnt - base_wv, 8);
        chk("b_done_count", done_cnt - base_done, 8);
        chk("b_log_size", done_log.size(), 8);
        for (int t = 0; t < 8 && t < done_log.size(); t++) chk("b_grant_order", done_log[t], exp_order[t]);

        // Timeout with no response.
        req_data[39:0] = 40'h00_CAFE_0001;
        req = 4'b0001;
        wait_wv(10, ok);
        chk("c_wvalid_seen", ok, 1'b1);
        cyc_in(1);
        req = '0;
        wait_done(1100, ok);
        chk("c_done_seen", ok, 1'b1);
        chk("c_latency", done_cyc - wv_cyc, 1024);
        chk("c_done", done, 4'b0001);
        chk("c_err", err, 1'b1);
        chk("c_rsp", rsp, 32'h0);

        // Response on the exact timeout cycle.
        req_data[39:0] = 40'h00_CAFE_0002;
        req = 4'b0001;
        wait_wv(10, ok);
        chk("d_wvalid_seen", ok, 1'b1);
        cyc_in(1);
        req = '0;
        cyc_in(1022);
        rvalid = 1'b1; rdata = 32'h0BAD_F00D;
        cyc_in(1);
        rvalid = 1'b0;
        sample();
        chk("d_latency", ncyc - wv_cyc, 1024);
        chk("d_done", done, 4'b0001);
        chk("d_err", err, 1'b0);
        chk("d_rsp", rsp, 32'h0BAD_F00D);

        // Reset mid-WAIT, then a late response.
        req_data[39:0]  = 40'h00_0000_00E0;
        req_data[119:80] = 40'h22_2222_2222;
        req = 4'b0100;
        wait_wv(10, ok);
        chk("e_wvalid_seen", ok, 1'b1);
        chk("e_wdata", wdata, 40'h22_2222_2222);
        cyc_in(1);
        req = '0;
        cyc_in(50);
        rn = 1'b0;
        base_done = done_cnt;
        cyc_in(2);
        rn = 1'b1;
        cyc_in(1);
        rvalid = 1'b1; rdata = 32'h5555_AAAA;
        cyc_in(1);
        rvalid = 1'b0;
        cyc_in(10);
        sample();
        chk("e_no_done", done_cnt - base_done, 0);
        chk("e_busy", busy, 1'b0);
        chk("e_rsp_cleared", rsp, 32'h0);
        cyc_in(1);
        req = 4'b1111;
        wait_wv(10, ok);
        chk("e_wvalid_seen2", ok, 1'b1);
        chk("e_grant0_wdata", wdata, 40'h00_0000_00E0);
        cyc_in(1);
        req = '0;
        rvalid = 1'b1; rdata = 32'h1234_0000;
        cyc_in(1);
        rvalid = 1'b0;
        sample();
        chk("e_done", done, 4'b0001);

        // Stray rvalid in IDLE, then a requester that drops req right after grant.
        cyc_in(2);
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        cyc_in(3);
        rvalid = 1'b0;
        cyc_in(2);
        sample();
        chk("f_rsp_held", rsp, 32'h1234_0000);
        chk("f_err_held", err, 1'b0);
        chk("f_idle_busy", busy, 1'b0);
        req_data[159:120] = 40'h33_0000_0033;
        cyc_in(1);
        req = 4'b1000;
        wait_wv(10, ok);
        chk("f_wvalid_seen", ok, 1'b1);
        chk("f_wdata", wdata, 40'h33_0000_0033);
        req = '0;
        cyc_in(5);
        rvalid = 1'b1; rdata = 32'h0F0F_0F0F;
        cyc_in(1);
        rvalid = 1'b0;
        sample();
        chk("f_done", done, 4'b1000);
        chk("f_rsp", rsp, 32'h0F0F_0F0F);
        cyc_in(3);
        sample();
        chk("f_abandoned_one", wv_cnt - done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
